// File: rtl/ifetch_stage.sv
// LEGv8 instruction-fetch stage: owns the PC, issues req/ack fetches and loads
// the IF/ID register, with branch redirect, load-use stall and a one-entry skid.
module ifetch_stage #(
    parameter logic [63:0] RESET_PC  = 64'h0,
    parameter logic [31:0] NOP_INSTR = 32'hD503201F
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        Stall,
    input  logic        PCSrc,
    input  logic [63:0] Branch_target,
    output logic        imem_req,
    output logic [63:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] Instruction,
    output logic [63:0] nPC,
    output logic        Valid
);

    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_FULL} state_t;

    state_t      state_q, state_d;
    logic [63:0] pc_q, pc_d;
    logic [63:0] tgt_q, tgt_d;
    logic        kill_q, kill_d;
    logic [31:0] skid_q, skid_d;
    logic [63:0] skid_pc4_q, skid_pc4_d;
    logic [31:0] instr_q, instr_d;
    logic [63:0] npc_q, npc_d;
    logic        valid_q, valid_d;

    logic [63:0] pcPlus4;
    logic [63:0] redirTarget;

    assign pcPlus4     = pc_q + 64'd4;
    assign redirTarget = {Branch_target[63:2], 2'b00};

    assign imem_req    = (state_q == S_FETCH);
    assign imem_addr   = pc_q;
    assign Instruction = instr_q;
    assign nPC         = npc_q;
    assign Valid       = valid_q;

    // A redirect during an unanswered request parks the target in tgt_q so that
    // imem_addr stays put until the stale response has been absorbed.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        tgt_d      = tgt_q;
        kill_d     = kill_q;
        skid_d     = skid_q;
        skid_pc4_d = skid_pc4_q;
        instr_d    = instr_q;
        npc_d      = npc_q;
        valid_d    = valid_q;

        if (PCSrc) begin
            valid_d = 1'b0;
            instr_d = NOP_INSTR;
            if ((state_q == S_FETCH) && !imem_ack) begin
                kill_d = 1'b1;
                tgt_d  = redirTarget;
            end else begin
                pc_d    = redirTarget;
                kill_d  = 1'b0;
                state_d = S_FETCH;
            end
        end else begin
            case (state_q)
                S_IDLE: state_d = S_FETCH;
                S_FETCH: begin
                    if (imem_ack) begin
                        if (kill_q) begin
                            kill_d = 1'b0;
                            pc_d   = tgt_q;
                            if (!Stall) begin
                                valid_d = 1'b0;
                                instr_d = NOP_INSTR;
                            end
                        end else if (!Stall) begin
                            instr_d = imem_rdata;
                            npc_d   = pcPlus4;
                            valid_d = 1'b1;
                            pc_d    = pcPlus4;
                        end else begin
                            skid_d     = imem_rdata;
                            skid_pc4_d = pcPlus4;
                            pc_d       = pcPlus4;
                            state_d    = S_FULL;
                        end
                    end else if (!Stall) begin
                        valid_d = 1'b0;
                        instr_d = NOP_INSTR;
                    end
                end
                S_FULL: begin
                    if (!Stall) begin
                        instr_d = skid_q;
                        npc_d   = skid_pc4_q;
                        valid_d = 1'b1;
                        state_d = S_FETCH;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            pc_q       <= RESET_PC;
            tgt_q      <= 64'd0;
            kill_q     <= 1'b0;
            skid_q     <= NOP_INSTR;
            skid_pc4_q <= 64'd0;
            instr_q    <= NOP_INSTR;
            npc_q      <= 64'd0;
            valid_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            tgt_q      <= tgt_d;
            kill_q     <= kill_d;
            skid_q     <= skid_d;
            skid_pc4_q <= skid_pc4_d;
            instr_q    <= instr_d;
            npc_q      <= npc_d;
            valid_q    <= valid_d;
        end
    end

endmodule

// File: tb/tb_ifetch_stage.sv
// Self-checking bench for ifetch_stage: directed scenarios plus random traffic
// compared against a flag-based behavioural model of the fetch stage.
module tb_ifetch_stage;

    localparam logic [31:0] NOP = 32'hD503201F;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        Stall = 1'b0;
    logic        PCSrc = 1'b0;
    logic [63:0] Branch_target = 64'd0;
    logic        imem_req;
    logic [63:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = 32'd0;
    logic [31:0] Instruction;
    logic [63:0] nPC;
    logic        Valid;

    int checks = 0;
    int failures = 0;

    ifetch_stage dut (
        .clk(clk), .reset(reset), .Stall(Stall), .PCSrc(PCSrc),
        .Branch_target(Branch_target), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata), .Instruction(Instruction),
        .nPC(nPC), .Valid(Valid)
    );

    always #5 clk = ~clk;

    // Reference model: a fetch is either outstanding (mBusy), parked in the skid,
    // or not yet issued; mKill means the outstanding response is stale.
    logic        mBusy, mHasSkid, mKill, mValid;
    logic [63:0] mPc, mRedirect, mSkidNpc, mNpc;
    logic [31:0] mSkidInstr, mInstr;

    function automatic logic [31:0] memFn(input logic [63:0] a);
        return (a[31:0] * 32'h9E3779B1) ^ a[63:32] ^ 32'h5A5A0F0F;
    endfunction

    task automatic modelReset();
        mBusy = 0; mHasSkid = 0; mKill = 0; mValid = 0;
        mPc = 64'd0; mRedirect = 64'd0; mSkidNpc = 64'd0; mNpc = 64'd0;
        mSkidInstr = NOP; mInstr = NOP;
    endtask

    task automatic modelAdvance(input logic st, input logic br, input logic [63:0] tg, input logic ak);
        logic [63:0] aligned;
        aligned = tg & ~64'd3;
        if (br) begin
            mValid = 0; mInstr = NOP; mHasSkid = 0;
            if (mBusy && !ak) begin
                mKill = 1; mRedirect = aligned;
            end else begin
                mPc = aligned; mKill = 0; mBusy = 1;
            end
        end else if (mHasSkid) begin
            if (!st) begin
                mInstr = mSkidInstr; mNpc = mSkidNpc; mValid = 1;
                mHasSkid = 0; mBusy = 1;
            end
        end else if (!mBusy) begin
            mBusy = 1;
        end else if (ak) begin
            if (mKill) begin
                mKill = 0; mPc = mRedirect;
                if (!st) begin mValid = 0; mInstr = NOP; end
            end else if (!st) begin
                mInstr = memFn(mPc); mNpc = mPc + 64'd4; mValid = 1; mPc = mPc + 64'd4;
            end else begin
                mSkidInstr = memFn(mPc); mSkidNpc = mPc + 64'd4;
                mPc = mPc + 64'd4; mHasSkid = 1; mBusy = 0;
            end
        end else if (!st) begin
            mValid = 0; mInstr = NOP;
        end
    endtask

    task automatic step(input logic st, input logic br, input logic [63:0] tg, input logic ak);
        Stall = st; PCSrc = br; Branch_target = tg; imem_ack = ak;
        imem_rdata = ak ? memFn(imem_addr) : $urandom;
        modelAdvance(st, br, tg, ak);
        @(posedge clk); #1;
        Stall = 0; PCSrc = 0; imem_ack = 0;
    endtask

    task automatic doReset();
        reset = 0; Stall = 0; PCSrc = 0; imem_ack = 0;
        modelReset();
        @(posedge clk); #1;
        reset = 1;
    endtask

    task automatic test_reset();
        doReset();
        reset = 0;
        #1;
        checks++;
        if ({Valid, Instruction, nPC, imem_req, imem_addr} !== {1'b0, NOP, 64'd0, 1'b0, 64'd0}) begin
            failures++;
            $display("FAIL reset_values got V=%b I=%h nPC=%h req=%b addr=%h", Valid, Instruction, nPC, imem_req, imem_addr);
        end
        @(posedge clk); #1;
        reset = 1;
    endtask

    task automatic test_zero_wait();
        doReset();
        for (int i = 0; i < 8; i++) begin
            step(0, 0, 64'd0, imem_req);
            checks++;
            if ({imem_req, imem_addr, Valid, Instruction, nPC} !== {mBusy, mPc, mValid, mInstr, mNpc}) begin
                failures++;
                $display("FAIL zero_wait cyc%0d got req=%b a=%h V=%b I=%h n=%h exp req=%b a=%h V=%b I=%h n=%h",
                         i, imem_req, imem_addr, Valid, Instruction, nPC, mBusy, mPc, mValid, mInstr, mNpc);
            end
            if (i == 1) begin
                checks++;
                if ({Valid, Instruction, nPC} !== {1'b1, memFn(64'd0), 64'd4}) begin
                    failures++;
                    $display("FAIL zero_wait_first got V=%b I=%h n=%h exp V=1 I=%h n=4", Valid, Instruction, nPC, memFn(64'd0));
                end
            end
        end
    endtask

    task automatic test_latency();
        int cnt;
        logic [63:0] prevAddr;
        logic ak;
        doReset();
        step(0, 0, 64'd0, 0);
        cnt = 0;
        for (int i = 0; i < 12; i++) begin
            prevAddr = imem_addr;
            ak = (cnt == 2);
            step(0, 0, 64'd0, ak);
            cnt = ak ? 0 : cnt + 1;
            checks++;
            if ({imem_req, imem_addr, Valid, Instruction, nPC} !== {mBusy, mPc, mValid, mInstr, mNpc}) begin
                failures++;
                $display("FAIL latency cyc%0d got a=%h V=%b I=%h n=%h exp a=%h V=%b I=%h n=%h",
                         i, imem_addr, Valid, Instruction, nPC, mPc, mValid, mInstr, mNpc);
            end
            if (!ak) begin
                checks++;
                if (imem_addr !== prevAddr) begin
                    failures++;
                    $display("FAIL addr_stable got %h exp %h", imem_addr, prevAddr);
                end
            end
        end
    endtask

    task automatic test_stall_skid();
        doReset();
        step(0, 0, 64'd0, 0);
        step(0, 0, 64'd0, 1);
        step(0, 0, 64'd0, 1);
        step(1, 0, 64'd0, 0);
        step(1, 0, 64'd0, 1);
        step(1, 0, 64'd0, 0);
        step(1, 0, 64'd0, 0);
        checks++;
        if ({imem_req, Valid, Instruction, nPC} !== {1'b0, 1'b1, memFn(64'd4), 64'd8}) begin
            failures++;
            $display("FAIL stall_frozen got req=%b V=%b I=%h n=%h exp req=0 V=1 I=%h n=8", imem_req, Valid, Instruction, nPC, memFn(64'd4));
        end
        step(0, 0, 64'd0, 0);
        checks++;
        if ({Valid, Instruction, nPC, imem_req, imem_addr} !== {1'b1, memFn(64'd8), 64'd12, 1'b1, 64'd12}) begin
            failures++;
            $display("FAIL skid_release got V=%b I=%h n=%h req=%b a=%h exp V=1 I=%h n=c req=1 a=c",
                     Valid, Instruction, nPC, imem_req, imem_addr, memFn(64'd8));
        end
    endtask

    task automatic test_redirect();
        doReset();
        step(0, 0, 64'd0, 0);
        for (int i = 0; i < 4; i++) step(0, 0, 64'd0, 1);
        step(0, 1, 64'h40, 0);
        checks++;
        if ({imem_req, imem_addr, Valid, Instruction} !== {1'b1, 64'h10, 1'b0, NOP}) begin
            failures++;
            $display("FAIL redirect_hold got req=%b a=%h V=%b I=%h exp req=1 a=10 V=0 I=%h", imem_req, imem_addr, Valid, Instruction, NOP);
        end
        step(0, 0, 64'd0, 1);
        checks++;
        if ({Valid, imem_addr} !== {1'b0, 64'h40}) begin
            failures++;
            $display("FAIL redirect_discard got V=%b a=%h exp V=0 a=40", Valid, imem_addr);
        end
        step(0, 0, 64'd0, 1);
        checks++;
        if ({Valid, Instruction, nPC} !== {1'b1, memFn(64'h40), 64'h44}) begin
            failures++;
            $display("FAIL redirect_target got V=%b I=%h n=%h exp V=1 I=%h n=44", Valid, Instruction, nPC, memFn(64'h40));
        end
        step(1, 1, 64'h103, 1);
        checks++;
        if ({Valid, Instruction, imem_req, imem_addr} !== {1'b0, NOP, 1'b1, 64'h100}) begin
            failures++;
            $display("FAIL redirect_stall got V=%b I=%h req=%b a=%h exp V=0 req=1 a=100", Valid, Instruction, imem_req, imem_addr);
        end
        step(0, 1, 64'hFFFF_FFFF_FFFF_FFFE, 1);
        step(0, 0, 64'd0, 1);
        checks++;
        if ({Valid, Instruction, nPC, imem_addr} !== {1'b1, memFn(64'hFFFF_FFFF_FFFF_FFFC), 64'd0, 64'd0}) begin
            failures++;
            $display("FAIL pc_wrap got V=%b I=%h n=%h a=%h exp V=1 n=0 a=0", Valid, Instruction, nPC, imem_addr);
        end
    endtask

    task automatic test_reset_midrequest();
        doReset();
        step(0, 0, 64'd0, 0);
        step(0, 0, 64'd0, 1);
        #2;
        reset = 0;
        imem_ack = 1;
        imem_rdata = 32'hDEAD_BEEF;
        #1;
        modelReset();
        checks++;
        if ({Valid, Instruction, nPC, imem_req, imem_addr} !== {1'b0, NOP, 64'd0, 1'b0, 64'd0}) begin
            failures++;
            $display("FAIL reset_async got V=%b I=%h n=%h req=%b a=%h", Valid, Instruction, nPC, imem_req, imem_addr);
        end
        @(posedge clk); #1;
        reset = 1;
        step(0, 0, 64'd0, 1);
        checks++;
        if ({Valid, imem_req, imem_addr} !== {1'b0, 1'b1, 64'd0}) begin
            failures++;
            $display("FAIL reset_ack_ignored got V=%b req=%b a=%h exp V=0 req=1 a=0", Valid, imem_req, imem_addr);
        end
        step(0, 0, 64'd0, 1);
        checks++;
        if ({Valid, Instruction, nPC} !== {1'b1, memFn(64'd0), 64'd4}) begin
            failures++;
            $display("FAIL reset_restart got V=%b I=%h n=%h exp V=1 I=%h n=4", Valid, Instruction, nPC, memFn(64'd0));
        end
    endtask

    task automatic test_random();
        logic st, br, ak;
        logic [63:0] tg;
        doReset();
        for (int i = 0; i < 600; i++) begin
            st = ($urandom_range(0, 3) == 0);
            br = ($urandom_range(0, 11) == 0);
            tg = {$urandom, $urandom};
            ak = mBusy ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 19) == 0);
            step(st, br, tg, ak);
            checks++;
            if ({imem_req, imem_addr, Valid, Instruction, nPC} !== {mBusy, mPc, mValid, mInstr, mNpc}) begin
                failures++;
                $display("FAIL random cyc%0d got req=%b a=%h V=%b I=%h n=%h exp req=%b a=%h V=%b I=%h n=%h",
                         i, imem_req, imem_addr, Valid, Instruction, nPC, mBusy, mPc, mValid, mInstr, mNpc);
            end
        end
    endtask

    initial begin
        modelReset();
        test_reset();
        test_zero_wait();
        test_latency();
        test_stall_skid();
        test_redirect();
        test_reset_midrequest();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
